// File: rtl/sha1_msg_feeder.sv
// Byte-stream front end for a SHA-1 core: packs bytes big-endian into 512-bit
// blocks, appends SHA-1 padding and streams each block as 16 words.
module sha1_msg_feeder #(
  parameter int LENBITS = 64,
  parameter int WORDNUM = 16
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [7:0]  iByte,
  input  logic        iByteValid,
  input  logic        iMsgEnd,
  output logic        oByteReady,
  output logic [31:0] oDat,
  output logic        oValid,
  output logic        oInitial,
  input  logic        iCoreReady,
  output logic        oDigestValid,
  output logic        oBusy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    PAD       = 3'd2,
    WAIT_CORE = 3'd3,
    BURST     = 3'd4,
    WAIT_DIG  = 3'd5
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [31:0]         buf_r [WORDNUM];
  logic [5:0]          ptr_r;
  logic [LENBITS-1:0]  len_r;
  logic [3:0]          idx_r;
  logic                first_r, last_r, end_pend_r, len_pend_r;
  logic                byte_ready_r, valid_r, initial_r, digest_r, busy_r;
  logic [31:0]         dat_r;

  logic [63:0]         len_ext_s;
  logic                take_byte_s, take_end_s, wrap_s;
  logic [31:0]         dat_nxt_s;
  logic                valid_nxt_s, initial_nxt_s, digest_nxt_s;
  logic                byte_ready_nxt_s, busy_nxt_s;

  // Merge one byte into a word; lane 0 is the most significant byte.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    case (lane)
      2'd0:    r = {b, w[23:0]};
      2'd1:    r = {w[31:24], b, w[15:0]};
      2'd2:    r = {w[31:16], b, w[7:0]};
      2'd3:    r = {w[31:8], b};
      default: r = w;
    endcase
    return r;
  endfunction

  assign len_ext_s   = 64'(len_r);
  assign take_byte_s = iByteValid & byte_ready_r;
  assign take_end_s  = iMsgEnd & byte_ready_r;
  assign wrap_s      = take_byte_s & (ptr_r == 6'd63);

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_end_s)       state_nxt_s = PAD;
        else if (take_byte_s) state_nxt_s = COLLECT;
        else                  state_nxt_s = IDLE;
      end
      COLLECT: begin
        if (wrap_s)          state_nxt_s = WAIT_CORE;
        else if (take_end_s) state_nxt_s = PAD;
        else                 state_nxt_s = COLLECT;
      end
      PAD:       state_nxt_s = WAIT_CORE;
      WAIT_CORE: begin
        if (iCoreReady) state_nxt_s = BURST;
        else            state_nxt_s = WAIT_CORE;
      end
      BURST: begin
        if (idx_r != 4'd15)  state_nxt_s = BURST;
        else if (last_r)     state_nxt_s = WAIT_DIG;
        else if (len_pend_r) state_nxt_s = WAIT_CORE;
        else if (end_pend_r) state_nxt_s = PAD;
        else                 state_nxt_s = COLLECT;
      end
      WAIT_DIG: begin
        if (iCoreReady) state_nxt_s = IDLE;
        else            state_nxt_s = WAIT_DIG;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode; every output is registered below
  always_comb begin
    dat_nxt_s     = 32'd0;
    valid_nxt_s   = 1'b0;
    initial_nxt_s = 1'b0;
    digest_nxt_s  = 1'b0;
    case (state_r)
      WAIT_CORE: begin
        if (iCoreReady) begin
          dat_nxt_s     = buf_r[0];
          valid_nxt_s   = 1'b1;
          initial_nxt_s = first_r;
        end else begin
          valid_nxt_s   = 1'b0;
        end
      end
      BURST: begin
        dat_nxt_s   = buf_r[idx_r];
        valid_nxt_s = 1'b1;
      end
      WAIT_DIG: begin
        if (iCoreReady) digest_nxt_s = 1'b1;
        else            digest_nxt_s = 1'b0;
      end
      default: valid_nxt_s = 1'b0;
    endcase
    byte_ready_nxt_s = (state_nxt_s == IDLE) || (state_nxt_s == COLLECT);
    busy_nxt_s       = (state_nxt_s != IDLE);
  end

  // Output registers; reset clears them immediately, even mid-burst
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      dat_r        <= 32'd0;
      valid_r      <= 1'b0;
      initial_r    <= 1'b0;
      digest_r     <= 1'b0;
      byte_ready_r <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      dat_r        <= dat_nxt_s;
      valid_r      <= valid_nxt_s;
      initial_r    <= initial_nxt_s;
      digest_r     <= digest_nxt_s;
      byte_ready_r <= byte_ready_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  // Block buffer, byte pointer, bit length and block-sequencing flags
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < WORDNUM; i++) buf_r[i] <= 32'd0;
      ptr_r      <= 6'd0;
      len_r      <= '0;
      idx_r      <= 4'd0;
      first_r    <= 1'b1;
      last_r     <= 1'b0;
      end_pend_r <= 1'b0;
      len_pend_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, COLLECT: begin
          if (take_byte_s) begin
            buf_r[ptr_r[5:2]] <= put_byte(buf_r[ptr_r[5:2]], ptr_r[1:0], iByte);
            ptr_r <= ptr_r + 6'd1;
            len_r <= len_r + LENBITS'(8);
          end
          if (wrap_s) begin
            last_r <= 1'b0;
            if (iMsgEnd) end_pend_r <= 1'b1;
          end
        end
        PAD: begin
          buf_r[ptr_r[5:2]] <= put_byte(buf_r[ptr_r[5:2]], ptr_r[1:0], 8'h80);
          if (ptr_r <= 6'd55) begin
            buf_r[14] <= len_ext_s[63:32];
            buf_r[15] <= len_ext_s[31:0];
            last_r    <= 1'b1;
          end else begin
            last_r     <= 1'b0;
            len_pend_r <= 1'b1;
          end
        end
        WAIT_CORE: begin
          if (iCoreReady) idx_r <= 4'd1;
        end
        BURST: begin
          idx_r <= idx_r + 4'd1;
          if (idx_r == 4'd15) begin
            for (int i = 0; i < WORDNUM; i++) buf_r[i] <= 32'd0;
            ptr_r   <= 6'd0;
            first_r <= 1'b0;
            // A deferred length block overrides the cleared length words
            if (!last_r && len_pend_r) begin
              buf_r[14]  <= len_ext_s[63:32];
              buf_r[15]  <= len_ext_s[31:0];
              last_r     <= 1'b1;
              len_pend_r <= 1'b0;
            end else if (!last_r && end_pend_r) begin
              end_pend_r <= 1'b0;
            end
          end
        end
        WAIT_DIG: begin
          if (iCoreReady) begin
            len_r   <= '0;
            first_r <= 1'b1;
            last_r  <= 1'b0;
          end
        end
        default: idx_r <= 4'd0;
      endcase
    end
  end

  assign oByteReady   = byte_ready_r;
  assign oDat         = dat_r;
  assign oValid       = valid_r;
  assign oInitial     = initial_r;
  assign oDigestValid = digest_r;
  assign oBusy        = busy_r;

endmodule
